// File: rtl/parity_serial_checker.sv
// parity_serial_checker
//   Receive side of a parity-protected serial link. Collects DATA_W data bits
//   (LSB first) followed by one parity bit, rebuilds the word, checks its parity
//   and presents the word together with a one-cycle frame_valid_o strobe.
//
// Parameters
//   DATA_W      data bits per frame (>= 1)
//   ODD_PARITY  0: even parity expected (p = ^data), 1: odd parity (p = ~^data)
//   CNT_W       width of the parity-error counter
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   bit_in_i       serial data / parity bit
//   bit_valid_i    bit_in_i valid this cycle
//   bit_start_i    marks the first data bit of a frame (only with bit_valid_i)
//   data_out_o     last received word, held until the next frame completes
//   frame_valid_o  one-cycle pulse when data_out_o / parity_err_o update
//   parity_err_o   parity result of the last frame, held with data_out_o
//   busy_o         high while a frame is in progress
//   err_count_o    saturating parity-error count
//
// Build option
//   PARITY_ERR_COUNT_EN  defined: error counter built; undefined: err_count_o = 0.

module parity_serial_checker #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bit_in_i,
  input  logic              bit_valid_i,
  input  logic              bit_start_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              frame_valid_o,
  output logic              parity_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  err_count_o
);

  // Bit counter must hold values 0..DATA_W.
  localparam int unsigned CntBits = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CntBits-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                fv_q, fv_d;
  logic                exp_par;

  assign exp_par = (^shift_q) ^ (ODD_PARITY != 0);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fv_d    = 1'b0;

    if (bit_valid_i && bit_start_i) begin
      // A start bit always opens a new frame; any partial frame is dropped silently.
      shift_d    = '0;
      shift_d[0] = bit_in_i;
      cnt_d      = CntBits'(1);
      state_d    = (DATA_W == 1) ? StParity : StData;
    end else if (bit_valid_i) begin
      unique case (state_q)
        StIdle: begin
          // Stray bit outside a frame: ignored.
        end
        StData: begin
          for (int i = 0; i < int'(DATA_W); i++) begin
            if (cnt_q == CntBits'(i)) shift_d[i] = bit_in_i;
          end
          cnt_d = cnt_q + CntBits'(1);
          if (cnt_q == CntBits'(DATA_W - 1)) state_d = StParity;
        end
        StParity: begin
          data_d  = shift_q;
          perr_d  = (bit_in_i != exp_par);
          fv_d    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fv_q    <= fv_d;
    end
  end

  assign data_out_o    = data_q;
  assign parity_err_o  = perr_q;
  assign frame_valid_o = fv_q;
  assign busy_o        = (state_q != StIdle);

`ifdef PARITY_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Counts on the same edge that raises frame_valid, so the count is current
  // while the strobe is visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (fv_d && perr_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_parity_serial_checker.sv
// Bench for parity_serial_checker: an even-parity instance (CNT_W=8) and an
// odd-parity instance (CNT_W=2) share one input stream. A table of directed
// vectors, hand sequences for gaps/reset/saturation and a random phase are all
// compared against a queue-based frame model.

module tb_parity_serial_checker;

  localparam int DW = 4;

  logic clk, rst, bit_in, bit_valid, bit_start;
  logic [DW-1:0] data_e, data_o;
  logic fv_e, fv_o, perr_e, perr_o, busy_e, busy_o;
  logic [7:0] cnt_e;
  logic [1:0] cnt_o;

  parity_serial_checker #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(8)) u_even (
    .clk_i(clk), .rst_i(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
    .bit_start_i(bit_start), .data_out_o(data_e), .frame_valid_o(fv_e),
    .parity_err_o(perr_e), .busy_o(busy_e), .err_count_o(cnt_e)
  );

  parity_serial_checker #(.DATA_W(DW), .ODD_PARITY(1), .CNT_W(2)) u_odd (
    .clk_i(clk), .rst_i(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
    .bit_start_i(bit_start), .data_out_o(data_o), .frame_valid_o(fv_o),
    .parity_err_o(perr_o), .busy_o(busy_o), .err_count_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Frame model: bits of the current frame kept in a queue.
  int   fb[$];
  bit   in_frame;
  int   m_data, m_perr_e, m_perr_o, m_fv, m_busy, m_cnt_e, m_cnt_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    fb.delete();
    in_frame = 0;
    m_data = 0; m_perr_e = 0; m_perr_o = 0; m_fv = 0; m_busy = 0;
    m_cnt_e = 0; m_cnt_o = 0;
  endtask

  task automatic model_clk(input bit v, input bit s, input bit b);
    int word, ones;
    m_fv = 0;
    if (v && s) begin
      fb.delete();
      fb.push_back(int'(b));
      in_frame = 1;
    end else if (v && in_frame) begin
      if (fb.size() < DW) begin
        fb.push_back(int'(b));
      end else begin
        word = 0;
        foreach (fb[i]) word += fb[i] * (1 << i);
        ones = $countones(word);
        m_data   = word;
        m_perr_e = (int'(b) != (ones % 2)) ? 1 : 0;
        m_perr_o = (int'(b) != (1 - ones % 2)) ? 1 : 0;
        m_fv     = 1;
        in_frame = 0;
`ifdef PARITY_ERR_COUNT_EN
        if (m_perr_e == 1 && m_cnt_e < 255) m_cnt_e++;
        if (m_perr_o == 1 && m_cnt_o < 3) m_cnt_o++;
`endif
      end
    end
    m_busy = in_frame ? 1 : 0;
  endtask

  task automatic check_all();
    chk("even_fv",   32'(fv_e),   32'(m_fv));
    chk("even_data", 32'(data_e), 32'(m_data));
    chk("even_perr", 32'(perr_e), 32'(m_perr_e));
    chk("even_busy", 32'(busy_e), 32'(m_busy));
    chk("even_cnt",  32'(cnt_e),  32'(m_cnt_e));
    chk("odd_fv",    32'(fv_o),   32'(m_fv));
    chk("odd_data",  32'(data_o), 32'(m_data));
    chk("odd_perr",  32'(perr_o), 32'(m_perr_o));
    chk("odd_busy",  32'(busy_o), 32'(m_busy));
    chk("odd_cnt",   32'(cnt_o),  32'(m_cnt_o));
  endtask

  // Called at active edge + 1: drive, clock, sample one unit later.
  task automatic step(input bit v, input bit s, input bit b);
    bit_valid = v;
    bit_start = s;
    bit_in    = b;
    @(posedge clk);
    #1;
    model_clk(v, s, b);
    check_all();
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    bit_start = 1'b0;
    bit_in    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clk(0, 0, 0);
    check_all();
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input bit p);
    for (int i = 0; i < DW; i++) step(1, i == 0, w[i]);
    step(1, 0, p);
  endtask

  typedef struct {
    bit       v, s, b;
    bit       fv;
    bit [3:0] data;
    bit       perr, busy;
  } vec_t;

  vec_t tbl[$];
  bit [1:0] sat_exp[5];

  initial begin
    // Expected outputs of the even instance after each clocked vector.
    tbl = '{
      '{1,1,1, 0, 4'h0, 0, 1}, '{1,0,1, 0, 4'h0, 0, 1},   // 0011, p=0
      '{1,0,0, 0, 4'h0, 0, 1}, '{1,0,0, 0, 4'h0, 0, 1},
      '{1,0,0, 1, 4'h3, 0, 0}, '{0,0,0, 0, 4'h3, 0, 0},
      '{1,0,1, 0, 4'h3, 0, 0}, '{0,1,1, 0, 4'h3, 0, 0},   // stray bit, start w/o valid
      '{1,1,1, 0, 4'h3, 0, 1}, '{1,0,1, 0, 4'h3, 0, 1},   // 0111, p=0 -> error
      '{1,0,1, 0, 4'h3, 0, 1}, '{1,0,0, 0, 4'h3, 0, 1},
      '{1,0,0, 1, 4'h7, 1, 0}, '{0,0,0, 0, 4'h7, 1, 0},
      '{1,1,1, 0, 4'h7, 1, 1}, '{1,0,0, 0, 4'h7, 1, 1},   // abort after 1,0
      '{1,1,1, 0, 4'h7, 1, 1}, '{1,0,1, 0, 4'h7, 1, 1},   // 1111, p=0
      '{1,0,1, 0, 4'h7, 1, 1}, '{1,0,1, 0, 4'h7, 1, 1},
      '{1,0,0, 1, 4'hF, 0, 0},
      '{1,1,0, 0, 4'hF, 0, 1}, '{1,0,0, 0, 4'hF, 0, 1},   // 0000/p0 then 0001/p1
      '{1,0,0, 0, 4'hF, 0, 1}, '{1,0,0, 0, 4'hF, 0, 1},
      '{1,0,0, 1, 4'h0, 0, 0},
      '{1,1,1, 0, 4'h0, 0, 1}, '{1,0,0, 0, 4'h0, 0, 1},
      '{1,0,0, 0, 4'h0, 0, 1}, '{1,0,0, 0, 4'h0, 0, 1},
      '{1,0,1, 1, 4'h1, 0, 0}, '{0,0,0, 0, 4'h1, 0, 0},
      '{1,1,1, 0, 4'h1, 0, 1}, '{1,0,1, 0, 4'h1, 0, 1},   // start during parity
      '{1,0,1, 0, 4'h1, 0, 1}, '{1,0,1, 0, 4'h1, 0, 1},
      '{1,1,0, 0, 4'h1, 0, 1}, '{1,0,0, 0, 4'h1, 0, 1},   // new frame 0100, p=1
      '{1,0,1, 0, 4'h1, 0, 1}, '{1,0,0, 0, 4'h1, 0, 1},
      '{1,0,1, 1, 4'h4, 0, 0}
    };
`ifdef PARITY_ERR_COUNT_EN
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    sat_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    rst = 1'b1;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    bit_start = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clk(0, 0, 0);
    check_all();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].b);
      chk($sformatf("tbl%0d_fv", i),   32'(fv_e),   32'(tbl[i].fv));
      chk($sformatf("tbl%0d_data", i), 32'(data_e), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_perr", i), 32'(perr_e), 32'(tbl[i].perr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_e), 32'(tbl[i].busy));
    end

    // 0101 with 0..3 idle cycles after each bit.
    for (int i = 0; i < DW; i++) begin
      step(1, i == 0, (i % 2) == 0);
      for (int g = 0; g < i; g++) begin
        step(0, 0, 1);
        chk("gap_busy", 32'(busy_e), 32'(1));
        chk("gap_fv", 32'(fv_e), 32'(0));
      end
    end
    step(0, 0, 0);
    chk("gap_prepar_fv", 32'(fv_e), 32'(0));
    step(1, 0, 0);
    chk("gap_fv_pulse", 32'(fv_e), 32'(1));
    chk("gap_data", 32'(data_e), 32'(5));
    chk("gap_perr", 32'(perr_e), 32'(0));
    chk("gap_busy_end", 32'(busy_e), 32'(0));
    step(0, 0, 0);
    chk("gap_fv_drop", 32'(fv_e), 32'(0));

    // Reset after two data bits, then a clean frame.
    step(1, 1, 1);
    step(1, 0, 1);
    do_reset();
    chk("rst_data", 32'(data_e), 32'(0));
    chk("rst_busy", 32'(busy_e), 32'(0));
    send_frame(4'b0011, 1'b0);
    chk("post_rst_fv", 32'(fv_e), 32'(1));
    chk("post_rst_data", 32'(data_e), 32'(3));
    chk("post_rst_perr", 32'(perr_e), 32'(0));

    // Odd instance sees 0000/p0 as bad: 2-bit counter saturates.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(4'b0000, 1'b0);
      chk($sformatf("sat%0d_cnt", k), 32'(cnt_o), 32'(sat_exp[k]));
      chk($sformatf("sat%0d_perr", k), 32'(perr_o), 32'(1));
      chk($sformatf("sat%0d_even_perr", k), 32'(perr_e), 32'(0));
    end

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
